hc153_scan_ctrl: RTL

//  Scan sequencer for the HC153 dual 4-to-1 mux. Steps select lines S1/S2 through

---
 rtl/hc153_pkg.sv | 14 +
 rtl/hc153_sync2.sv | 21 ++
 rtl/hc153_scan_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hc153_pkg.sv
// Shared types and sizes for the HC153 scan sequencer.
package hc153_pkg;

  localparam int unsigned CH_W   = 2;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    DONE
  } state_t;

endpackage

// File: rtl/hc153_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module hc153_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hc153_scan_ctrl.sv
// Scan sequencer for the HC153 dual 4-to-1 mux: steps channels 0..3, samples
// Y1/Y2 and presents an 8-bit snapshot on a valid/ready port.
module hc153_scan_ctrl
  import hc153_pkg::*;
#(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned AUTO   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              s1,
  output logic              s2,
  output logic              e1n,
  output logic              e2n,
  input  logic              y1,
  input  logic              y2,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready
);

  localparam int unsigned DWELL_D = SETTLE + 2;
  localparam int unsigned CNT_W   = $clog2(DWELL_D);

  state_t              state;
  logic                start_q;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   shadow;
  logic [DATA_W-1:0]   cap_c;
  logic [CH_W-1:0]     ch_c;
  logic                y1_s;
  logic                y2_s;
  logic                cnt_done_c;
  logic                last_ch_c;

  hc153_sync2 u_sync_y1 (.clk(clk), .rst(rst), .d(y1), .q(y1_s));
  hc153_sync2 u_sync_y2 (.clk(clk), .rst(rst), .d(y2), .q(y2_s));

  assign ch_c       = {s1, s2};
  assign cnt_done_c = (cnt == CNT_W'(DWELL_D - 1));
  assign last_ch_c  = (ch_c == CH_W'(NUM_CH - 1));

  // Shadow with the current channel's synced samples merged in.
  always_comb begin
    cap_c                = shadow;
    cap_c[{1'b0, ch_c}]  = y1_s;
    cap_c[{1'b1, ch_c}]  = y2_s;
  end

  // A start seen in IDLE is held one cycle in start_q before the first dwell,
  // which aligns the first channel with the cycle after busy rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      start_q <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      e1n     <= 1'b1;
      e2n     <= 1'b1;
      shadow  <= '0;
      data    <= '0;
      valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_q) begin
            start_q  <= 1'b0;
            state    <= DWELL;
            cnt      <= '0;
            {s1, s2} <= '0;
            e1n      <= 1'b0;
            e2n      <= 1'b0;
          end else if (start) begin
            start_q <= 1'b1;
            busy    <= 1'b1;
          end
        end
        DWELL: begin
          if (cnt_done_c) begin
            shadow <= cap_c;
            if (last_ch_c) begin
              state    <= DONE;
              data     <= cap_c;
              valid    <= 1'b1;
              busy     <= 1'b0;
              {s1, s2} <= '0;
              e1n      <= 1'b1;
              e2n      <= 1'b1;
            end else begin
              {s1, s2} <= ch_c + CH_W'(1);
              cnt      <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // valid is always high here, so ready alone completes the handshake.
          if (ready) begin
            valid <= 1'b0;
            if (AUTO != 0) begin
              state <= DWELL;
              cnt   <= '0;
              busy  <= 1'b1;
              e1n   <= 1'b0;
              e2n   <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
